game_sequencer: RTL and testbench

Single-clock game controller for the FlappyFish top level. It owns the run/pause/over state machine, the bird/pipe/coin stop signal, and per-pipe coin visibility. It also owns pipe and coin score counting and the difficulty setting. It turns the asynchronous pipe-pass and coin-collect flags from the pipe and collision_checker instances into synchronous, arbitration-free events. All simultaneous events are counted; none are dropped.

---
 rtl/flappy_pkg.sv | 21 ++
 rtl/rise_detect.sv | 26 ++
 rtl/game_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared types and constants for the FlappyFish game controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  // USB HID keycodes for the digit keys 1..3 select the pipe speed.
  localparam logic [7:0] KEY_DIFF1 = 8'h1E;
  localparam logic [7:0] KEY_DIFF2 = 8'h1F;
  localparam logic [7:0] KEY_DIFF3 = 8'h20;

  localparam int MAX_SCORE    = 999;
  localparam int GRACE_FRAMES = 8;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one previous-value register per bit, rise = in & ~prev.
// Latency: combinational output in the cycle the input first reads high.
// Backpressure: none.
// Ports: Clk, Reset (sync, active-high), i_in[W], o_rise[W].
module rise_detect #(
  parameter int W = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [W-1:0] i_in,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_prev;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_prev <= '0;
    end else begin
      r_prev <= i_in;
    end
  end

  assign o_rise = i_in & ~r_prev;

endmodule

// File: rtl/game_sequencer.sv
// Game controller: run/pause/over FSM, freeze signal, coin visibility, score and difficulty.
// Latency: an input edge seen in cycle n shows in the registered outputs at cycle n+1.
// Backpressure: none; every simultaneous pipe/coin edge is counted in the same cycle.
// Ports: Clk, Reset (sync, active-high); vs (frame tick on rising edge), continue_btn,
//   keycode[8], new_pipe[N_PIPES], coin_hit[N_PIPES], collision in;
//   game_stop, restart, coin_visible[N_PIPES], num_pipes[CNT_W], num_coins[CNT_W],
//   difficulty[2], state[2] out; best_score[CNT_W] out when HIGH_SCORE_EN is defined.
// Optional feature macro: HIGH_SCORE_EN (best score register kept across restarts).
module game_sequencer
  import flappy_pkg::*;
#(
  parameter int N_PIPES      = 4,
  parameter int CNT_W        = 10,
  parameter int MAX_SCORE    = flappy_pkg::MAX_SCORE,
  parameter int GRACE_FRAMES = flappy_pkg::GRACE_FRAMES
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               vs,
  input  logic               continue_btn,
  input  logic [7:0]         keycode,
  input  logic [N_PIPES-1:0] new_pipe,
  input  logic [N_PIPES-1:0] coin_hit,
  input  logic               collision,
  output logic               game_stop,
  output logic               restart,
  output logic [N_PIPES-1:0] coin_visible,
  output logic [CNT_W-1:0]   num_pipes,
  output logic [CNT_W-1:0]   num_coins,
  output logic [1:0]         difficulty,
`ifdef HIGH_SCORE_EN
  output logic [CNT_W-1:0]   best_score,
`endif
  output logic [1:0]         state
);

  // Sum width leaves headroom so a near-max score plus several edges never wraps
  // before saturation.
  localparam int SW = CNT_W + 3;
  localparam int GW = $clog2(GRACE_FRAMES + 1);

  game_state_t        r_state, w_state_nxt;
  logic               r_game_stop;
  logic               r_restart;
  logic [N_PIPES-1:0] r_coin_visible;
  logic [CNT_W-1:0]   r_num_pipes;
  logic [CNT_W-1:0]   r_num_coins;
  logic [1:0]         r_difficulty;
  logic [GW-1:0]      r_grace;

  logic               w_vs_e;
  logic               w_cont_e;
  logic [N_PIPES-1:0] w_pipe_e;
  logic [N_PIPES-1:0] w_coin_e;
  logic [N_PIPES-1:0] w_coin_cnt;
  logic [N_PIPES-1:0] w_coin_vis_nxt;
  logic [SW-1:0]      w_pipe_sum;
  logic [SW-1:0]      w_coin_sum;
  logic [CNT_W-1:0]   w_pipe_sat;
  logic [CNT_W-1:0]   w_coin_sat;

  rise_detect #(.W(1)) u_rd_vs (
    .Clk(Clk), .Reset(Reset), .i_in(vs), .o_rise(w_vs_e)
  );
  rise_detect #(.W(1)) u_rd_cont (
    .Clk(Clk), .Reset(Reset), .i_in(continue_btn), .o_rise(w_cont_e)
  );
  rise_detect #(.W(N_PIPES)) u_rd_pipe (
    .Clk(Clk), .Reset(Reset), .i_in(new_pipe), .o_rise(w_pipe_e)
  );
  rise_detect #(.W(N_PIPES)) u_rd_coin (
    .Clk(Clk), .Reset(Reset), .i_in(coin_hit), .o_rise(w_coin_e)
  );

  // A coin counts only if it is currently drawn and its own pipe did not
  // re-arm it in the same cycle (the pipe edge wins).
  assign w_coin_cnt     = w_coin_e & r_coin_visible & ~w_pipe_e;
  assign w_coin_vis_nxt = (r_coin_visible | w_pipe_e) & ~w_coin_cnt;

  // Parallel popcount of all indices; no priority between pipes.
  always_comb begin
    w_pipe_sum = {3'b000, r_num_pipes};
    w_coin_sum = {3'b000, r_num_coins};
    for (int i = 0; i < N_PIPES; i++) begin
      w_pipe_sum = w_pipe_sum + SW'(w_pipe_e[i]);
      w_coin_sum = w_coin_sum + SW'(w_coin_cnt[i]);
    end
    w_pipe_sat = (w_pipe_sum > SW'(MAX_SCORE)) ? CNT_W'(MAX_SCORE) : w_pipe_sum[CNT_W-1:0];
    w_coin_sat = (w_coin_sum > SW'(MAX_SCORE)) ? CNT_W'(MAX_SCORE) : w_coin_sum[CNT_W-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_cont_e) w_state_nxt = RUN;
      // Collision is checked first so it beats a simultaneous continue press.
      RUN: begin
        if (collision && (r_grace == '0)) w_state_nxt = OVER;
        else if (w_cont_e)                w_state_nxt = PAUSE;
      end
      PAUSE: if (w_cont_e) w_state_nxt = RUN;
      OVER:  if (w_cont_e) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef HIGH_SCORE_EN
  logic [CNT_W-1:0] r_best_score;
  logic [SW-1:0]    w_total_sum;
  logic [CNT_W-1:0] w_total_sat;

  assign w_total_sum = {3'b000, r_num_pipes} + {3'b000, r_num_coins};
  assign w_total_sat = (w_total_sum > SW'(MAX_SCORE)) ? CNT_W'(MAX_SCORE) : w_total_sum[CNT_W-1:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_best_score <= '0;
    end else if ((r_state == OVER) && w_cont_e && (w_total_sat > r_best_score)) begin
      r_best_score <= w_total_sat;
    end
  end

  assign best_score = r_best_score;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_game_stop    <= 1'b1;
      r_restart      <= 1'b0;
      r_coin_visible <= '1;
      r_num_pipes    <= '0;
      r_num_coins    <= '0;
      r_difficulty   <= 2'd1;
      r_grace        <= '0;
    end else begin
      // Derived from next state so the freeze tracks the state register exactly.
      r_game_stop <= (w_state_nxt != RUN);
      r_restart   <= 1'b0;

      // Grace is loaded only on a fresh start, not on resume from pause.
      if ((r_state == IDLE) && w_cont_e) begin
        r_grace <= GW'(GRACE_FRAMES);
      end else if ((r_state == RUN) && w_vs_e && (r_grace != '0)) begin
        r_grace <= r_grace - GW'(1);
      end

      if (r_state == RUN) begin
        r_num_pipes    <= w_pipe_sat;
        r_num_coins    <= w_coin_sat;
        r_coin_visible <= w_coin_vis_nxt;
      end else if ((r_state == OVER) && w_cont_e) begin
        r_restart      <= 1'b1;
        r_num_pipes    <= '0;
        r_num_coins    <= '0;
        r_coin_visible <= '1;
      end

      if (((r_state == IDLE) || (r_state == PAUSE)) && w_vs_e) begin
        case (keycode)
          KEY_DIFF1: r_difficulty <= 2'd1;
          KEY_DIFF2: r_difficulty <= 2'd2;
          KEY_DIFF3: r_difficulty <= 2'd3;
          default:   r_difficulty <= r_difficulty;
        endcase
      end
    end
  end

  assign game_stop    = r_game_stop;
  assign restart      = r_restart;
  assign coin_visible = r_coin_visible;
  assign num_pipes    = r_num_pipes;
  assign num_coins    = r_num_coins;
  assign difficulty   = r_difficulty;
  assign state        = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer.
// Inputs are driven 1 ns after the rising edge; outputs are checked 1 ns after the next.
module tb_game_sequencer;

  logic       Clk;
  logic       Reset;
  logic       vs;
  logic       continue_btn;
  logic [7:0] keycode;
  logic [3:0] new_pipe;
  logic [3:0] coin_hit;
  logic       collision;
  logic       game_stop;
  logic       restart;
  logic [3:0] coin_visible;
  logic [9:0] num_pipes;
  logic [9:0] num_coins;
  logic [1:0] difficulty;
  logic [1:0] state;
`ifdef HIGH_SCORE_EN
  logic [9:0] best_score;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  game_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .vs           (vs),
    .continue_btn (continue_btn),
    .keycode      (keycode),
    .new_pipe     (new_pipe),
    .coin_hit     (coin_hit),
    .collision    (collision),
    .game_stop    (game_stop),
    .restart      (restart),
    .coin_visible (coin_visible),
    .num_pipes    (num_pipes),
    .num_coins    (num_coins),
    .difficulty   (difficulty),
`ifdef HIGH_SCORE_EN
    .best_score   (best_score),
`endif
    .state        (state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Raise continue for one edge; caller checks, then ticks to let it settle.
  task automatic press();
    continue_btn = 1'b1;
    tick();
    continue_btn = 1'b0;
  endtask

  task automatic frame();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();
  endtask

  task automatic evt(input logic [3:0] p, input logic [3:0] c);
    new_pipe = p;
    coin_hit = c;
    tick();
    new_pipe = 4'b0000;
    coin_hit = 4'b0000;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; vs = 1'b0; continue_btn = 1'b0; keycode = 8'h00;
    new_pipe = 4'b0000; coin_hit = 4'b0000; collision = 1'b0;
    tick();
    tick();
    chk("rst_state",  state, 0);
    chk("rst_stop",   game_stop, 1);
    chk("rst_restart", restart, 0);
    chk("rst_vis",    coin_visible, 4'b1111);
    chk("rst_pipes",  num_pipes, 0);
    chk("rst_coins",  num_coins, 0);
    chk("rst_diff",   difficulty, 1);
    Reset = 1'b0;
    tick();

    // Start, then collision masked for the grace window.
    press();
    chk("start_state", state, 1);
    chk("start_stop",  game_stop, 0);
    tick();
    collision = 1'b1;
    repeat (7) frame();
    chk("grace7_state", state, 1);
    frame();
    chk("grace8_state", state, 3);
    chk("over_stop",    game_stop, 1);
    collision = 1'b0;

    press();
    chk("rst1_restart", restart, 1);
    chk("rst1_state",   state, 0);
    tick();
    chk("rst1_pulse_end", restart, 0);

    keycode = 8'h20;
    frame();
    chk("diff_idle3", difficulty, 3);

    press();
    chk("run2_state", state, 1);
    tick();
    keycode = 8'h1E;
    frame();
    chk("diff_run_hold", difficulty, 3);
    keycode = 8'h00;

    evt(4'b0101, 4'b0000);
    chk("pipe2_cnt", num_pipes, 2);
    chk("pipe2_vis", coin_visible, 4'b1111);
    evt(4'b0000, 4'b0111);
    chk("coin3_cnt", num_coins, 3);
    chk("coin3_vis", coin_visible, 4'b1000);
    evt(4'b0000, 4'b0100);
    chk("coin_dup_cnt", num_coins, 3);
    evt(4'b0100, 4'b0000);
    chk("rearm_pipes", num_pipes, 3);
    chk("rearm_vis",   coin_visible, 4'b1100);
    evt(4'b0100, 4'b0100);
    chk("same_pipes", num_pipes, 4);
    chk("same_coins", num_coins, 3);
    chk("same_vis",   coin_visible, 4'b1100);

    press();
    chk("pause_state", state, 2);
    chk("pause_stop",  game_stop, 1);
    tick();
    keycode = 8'h1F;
    frame();
    chk("diff_pause2", difficulty, 2);
    keycode = 8'h00;
    evt(4'b0001, 4'b0000);
    chk("pause_discard", num_pipes, 4);
    press();
    chk("resume_state", state, 1);
    tick();

    repeat (248) evt(4'b1111, 4'b0000);
    chk("pre_996", num_pipes, 996);
    evt(4'b0011, 4'b0000);
    chk("pre_998", num_pipes, 998);
    evt(4'b1111, 4'b0000);
    chk("sat_999", num_pipes, 999);
    evt(4'b1111, 4'b0000);
    chk("sat_hold", num_pipes, 999);
    evt(4'b0000, 4'b1111);
    chk("coin4_cnt", num_coins, 7);
    chk("coin4_vis", coin_visible, 4'b0000);

    // Remaining grace is 7 frames; the extra frame lands in OVER.
    collision = 1'b1;
    repeat (8) frame();
    chk("over2_state", state, 3);
    collision = 1'b0;
`ifdef HIGH_SCORE_EN
    chk("best_before", best_score, 0);
`endif

    press();
    chk("rst2_restart", restart, 1);
    chk("rst2_state",   state, 0);
    chk("rst2_pipes",   num_pipes, 0);
    chk("rst2_coins",   num_coins, 0);
    chk("rst2_vis",     coin_visible, 4'b1111);
    chk("rst2_stop",    game_stop, 1);
`ifdef HIGH_SCORE_EN
    chk("best_after", best_score, 999);
`endif
    tick();
    chk("rst2_pulse_end", restart, 0);

    press();
    tick();
    evt(4'b0001, 4'b0000);
    evt(4'b0000, 4'b0010);
    chk("run3_pipes", num_pipes, 1);
    chk("run3_vis",   coin_visible, 4'b1101);
    Reset = 1'b1;
    tick();
    chk("mid_state",   state, 0);
    chk("mid_stop",    game_stop, 1);
    chk("mid_restart", restart, 0);
    chk("mid_vis",     coin_visible, 4'b1111);
    chk("mid_pipes",   num_pipes, 0);
    chk("mid_coins",   num_coins, 0);
    chk("mid_diff",    difficulty, 1);
`ifdef HIGH_SCORE_EN
    chk("mid_best",    best_score, 0);
`endif
    Reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
